// File: rtl/rt_port_arbiter.sv
// rt_port_arbiter
//   Round-robin arbiter that shares one router output channel between NUM_IN
//   input channels using the 4-phase (return-to-zero) req/ack/data protocol.
//   The winner's flit is registered, the downstream handshake runs to
//   completion, and only then is the winner acknowledged upstream.
//
// Parameters
//   NUM_IN : number of requesting input channels (2..8)
//   WIDTH  : flit width
//   IDX_W  : grant index width, $clog2(NUM_IN)
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_req     in   [NUM_IN]        per-input request
//   in_data    in   [NUM_IN*WIDTH]  per-input flit, slice i = [i*WIDTH +: WIDTH]
//   in_ack     out  [NUM_IN]        per-input acknowledge (one-hot or zero)
//   out_req    out  downstream request
//   out_data   out  [WIDTH]         registered flit of the current winner
//   out_ack    in   downstream acknowledge
//   busy       out  high whenever the FSM is not in IDLE
//   grant_idx  out  [IDX_W]         index of the current or last winner
//
// Optional build macro RT_ARB_STATS_EN adds:
//   stats_clr  in   synchronous clear of all grant counters (beats increment)
//   grant_cnt  out  [NUM_IN*16]     saturating completed-grant count per input

module rt_port_arbiter #(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 512,
  parameter int IDX_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       in_req,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ack,
  output logic                    out_req,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    out_ack,
  output logic                    busy,
`ifdef RT_ARB_STATS_EN
  input  logic                    stats_clr,
  output logic [NUM_IN*16-1:0]    grant_cnt,
`endif
  output logic [IDX_W-1:0]        grant_idx
);

  typedef enum logic [1:0] {IDLE, SEND, RELEASE, ACK_IN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win_idx;
  logic             xfer_done;
  logic [WIDTH-1:0] in_slice [NUM_IN];

  // Rotating-priority pick: the requester at the smallest circular distance
  // after p wins, so the last winner (p) is always considered last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_IN-1:0] req,
                                               input logic [IDX_W-1:0]  p);
    logic [IDX_W-1:0] best;
    int               best_d;
    int               d;
    best   = '0;
    best_d = NUM_IN;
    for (int i = 0; i < NUM_IN; i++) begin
      d = (i + 2 * NUM_IN - int'(p) - 1) % NUM_IN;
      if (req[i] && (d < best_d)) begin
        best_d = d;
        best   = IDX_W'(i);
      end
    end
    return best;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      in_slice[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign win_idx   = rr_pick(in_req, ptr);
  assign xfer_done = (state == ACK_IN) && !in_req[grant_idx];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|in_req)            state_nxt = SEND;
      SEND:    if (out_ack)            state_nxt = RELEASE;
      RELEASE: if (!out_ack)           state_nxt = ACK_IN;
      ACK_IN:  if (!in_req[grant_idx]) state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Outputs are pure decodes of the state flop and the grant register, so
  // nothing combinational reaches them from the inputs.
  always_comb begin
    out_req = (state == SEND);
    busy    = (state != IDLE);
    in_ack  = '0;
    if (state == ACK_IN) begin
      in_ack[grant_idx] = 1'b1;
    end
  end

  // Grant capture and priority pointer. The pointer only moves when the
  // upstream handshake completes, so an aborted transfer does not rotate it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      grant_idx <= '0;
      ptr       <= IDX_W'(NUM_IN - 1);
    end else begin
      if ((state == IDLE) && (|in_req)) begin
        out_data  <= in_slice[win_idx];
        grant_idx <= win_idx;
      end
      if (xfer_done) begin
        ptr <= grant_idx;
      end
    end
  end

`ifdef RT_ARB_STATS_EN
  logic [15:0] cnt [NUM_IN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_IN; i++) cnt[i] <= '0;
    end else if (stats_clr) begin
      for (int i = 0; i < NUM_IN; i++) cnt[i] <= '0;
    end else if (xfer_done && (cnt[grant_idx] != 16'hFFFF)) begin
      cnt[grant_idx] <= cnt[grant_idx] + 16'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      grant_cnt[i*16 +: 16] = cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_rt_port_arbiter.sv
// Directed plus randomized bench for rt_port_arbiter (NUM_IN=4, WIDTH=32).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_rt_port_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_req;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ack;
  logic           out_req;
  logic [W-1:0]   out_data;
  logic           out_ack;
  logic           busy;
  logic [1:0]     grant_idx;
`ifdef RT_ARB_STATS_EN
  logic           stats_clr;
  logic [N*16-1:0] grant_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int last_g;          // model: most recently completed winner
  int cnt_m [N];       // model: completed grants per input
  int g;

  rt_port_arbiter #(.NUM_IN(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_req    (in_req),
    .in_data   (in_data),
    .in_ack    (in_ack),
    .out_req   (out_req),
    .out_data  (out_data),
    .out_ack   (out_ack),
    .busy      (busy),
`ifdef RT_ARB_STATS_EN
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt),
`endif
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  // Walk forward from the last winner, wrapping, and take the first requester.
  function automatic int ref_pick(input logic [N-1:0] req, input int lastw);
    int k;
    k = lastw;
    for (int step = 0; step < N; step++) begin
      k = (k == N - 1) ? 0 : k + 1;
      if (((req >> k) & 4'd1) != 4'd0) return k;
    end
    return -1;
  endfunction

  function automatic logic [63:0] onehot(input int idx);
    logic [63:0] v;
    v = 64'd1 << idx;
    return v;
  endfunction

  task automatic model_reset();
    last_g = N - 1;
    for (int i = 0; i < N; i++) cnt_m[i] = 0;
  endtask

  // One full transfer, starting on a falling edge with the DUT in IDLE.
  task automatic txn(input logic [N-1:0] reqs, input logic [N*W-1:0] dat,
                     input int hold, input bit drop_early, input bit early_ack,
                     input bit clr, output int gw);
    logic [W-1:0] expd;
    in_req  = reqs;
    in_data = dat;
    if (early_ack) out_ack = 1'b1;
    gw   = ref_pick(reqs, last_g);
    expd = dat[gw*W +: W];
    @(negedge clk);
    chk("grant_req",   64'(out_req),   64'd1);
    chk("grant_idx",   64'(grant_idx), 64'(gw));
    chk("grant_data",  64'(out_data),  64'(expd));
    chk("grant_busy",  64'(busy),      64'd1);
    chk("grant_noack", 64'(in_ack),    64'd0);
    if (drop_early) in_req = in_req & ~(4'b0001 << gw);
    if (!early_ack) begin
      for (int c = 0; c < hold; c++) begin
        in_data = rand_data();
        @(negedge clk);
        chk("hold_req",   64'(out_req),  64'd1);
        chk("hold_data",  64'(out_data), 64'(expd));
        chk("hold_noack", 64'(in_ack),   64'd0);
      end
      out_ack = 1'b1;
    end
    @(negedge clk);
    chk("rel_req",   64'(out_req), 64'd0);
    chk("rel_busy",  64'(busy),    64'd1);
    chk("rel_noack", 64'(in_ack),  64'd0);
    out_ack = 1'b0;
    @(negedge clk);
    chk("ackin_ack",  64'(in_ack), onehot(gw));
    chk("ackin_busy", 64'(busy),   64'd1);
    in_req = in_req & ~(4'b0001 << gw);
`ifdef RT_ARB_STATS_EN
    stats_clr = clr;
`endif
    @(negedge clk);
    chk("done_ack",  64'(in_ack), 64'd0);
    chk("done_busy", 64'(busy),   64'd0);
`ifdef RT_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    last_g = gw;
    if (clr) begin
      for (int i = 0; i < N; i++) cnt_m[i] = 0;
    end else if (cnt_m[gw] < 65535) begin
      cnt_m[gw]++;
    end
  endtask

  initial begin
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    rst_n   = 1'b0;
    in_req  = '0;
    in_data = '0;
    out_ack = 1'b0;
`ifdef RT_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    model_reset();
    #1;
    chk("rst_out_req",   64'(out_req),   64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_in_ack",    64'(in_ack),    64'd0);
    chk("rst_grant_idx", 64'(grant_idx), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
    end

    // All four keep requesting: strict rotation from input 0
    for (int t = 0; t < 5; t++) begin
      txn(4'hF, rand_data(), 1, 1'b0, 1'b0, 1'b0, g);
      chk("rr_order", 64'(g), 64'(exp_order[t]));
    end
    in_req = '0;
    @(negedge clk);

    // Single requester on input 2 carrying 'hA5
    begin
      logic [N*W-1:0] d;
      d = rand_data();
      d[2*W +: W] = 32'hA5;
      txn(4'b0100, d, 2, 1'b0, 1'b0, 1'b0, g);
      chk("single_idx", 64'(g), 64'd2);
    end

    // Requester 1 withdraws during SEND; the transfer still completes
    txn(4'b0010, rand_data(), 2, 1'b1, 1'b0, 1'b0, g);
    chk("drop_idx", 64'(g), 64'd1);

    // Downstream stalls 20 cycles
    txn(4'b1000, rand_data(), 20, 1'b0, 1'b0, 1'b0, g);

    // out_ack already high when SEND is entered
    txn(4'b0001, rand_data(), 0, 1'b0, 1'b1, 1'b0, g);

    // Asynchronous reset in the middle of SEND
    in_req  = 4'hF;
    in_data = rand_data();
    @(negedge clk);
    chk("pre_rst_req", 64'(out_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_req",  64'(out_req),   64'd0);
    chk("arst_busy",     64'(busy),      64'd0);
    chk("arst_grant",    64'(grant_idx), 64'd0);
    chk("arst_out_data", 64'(out_data),  64'd0);
    model_reset();
    in_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(4'hF, rand_data(), 1, 1'b0, 1'b0, 1'b0, g);
    chk("post_rst_first", 64'(g), 64'd0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      int gap;
      txn(4'($urandom_range(1, 15)), rand_data(), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, g);
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        in_req = '0;
        repeat (gap) begin
          @(negedge clk);
          chk("gap_busy", 64'(busy), 64'd0);
        end
      end
    end
    in_req = '0;
    @(negedge clk);

`ifdef RT_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("cnt_rand", 64'(grant_cnt[i*16 +: 16]), 64'(cnt_m[i]));
    txn(4'b0010, rand_data(), 0, 1'b0, 1'b0, 1'b1, g);
    for (int i = 0; i < N; i++) chk("cnt_clr", 64'(grant_cnt[i*16 +: 16]), 64'd0);
    repeat (3) begin
      txn(4'b0010, rand_data(), 1, 1'b0, 1'b0, 1'b0, g);
      @(negedge clk);
    end
    chk("cnt1_three", 64'(grant_cnt[16 +: 16]), 64'd3);
    for (int i = 0; i < N; i++) chk("cnt_final", 64'(grant_cnt[i*16 +: 16]), 64'(cnt_m[i]));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
